// File: rtl/disk_image_pkg.sv
// Shared types and geometry defaults for the disk image loader.
package disk_image_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RECEIVE   = 2'd1,
    WAIT_STOP = 2'd2
  } state_t;

  localparam int DSK_TRACKS      = 35;
  localparam int DSK_TRACK_BYTES = 6656;

  // Bits needed to index n items, never less than one.
  function automatic int addr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/disk_image_loader_strobe_sync.sv
// Two-flop synchroniser with rising-edge detect for slow PS-to-PL strobes.
module strobe_sync (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic strobe
);

  logic [1:0] sync_q;
  logic       prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= 2'b00;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], async_in};
      prev_q <= sync_q[1];
    end
  end

  assign strobe = sync_q[1] & ~prev_q;

endmodule

// File: rtl/disk_image_loader.sv
// Receives a strobed disk image from the PS and issues track RAM writes.
// Optional DISK_IMAGE_LOADER_CKSUM_EN adds a byte checksum verified by the stop byte.
//
// state     | meaning
// IDLE      | waiting for a start cycle
// RECEIVE   | writing image bytes, one per data strobe
// WAIT_STOP | image complete, waiting for the stop cycle
module disk_image_loader
  import disk_image_pkg::*;
#(
  parameter int NUM_DRIVES  = 2,
  parameter int TRACKS      = DSK_TRACKS,
  parameter int TRACK_BYTES = DSK_TRACK_BYTES,
  parameter int DATA_W      = 8,
  parameter int DRIVE_W     = addr_width(NUM_DRIVES),
  parameter int ADDR_W      = addr_width(TRACKS * TRACK_BYTES)
) (
  input  logic                  CLK_14M,
  input  logic                  RESET,
  input  logic                  image_clk,
  input  logic                  image_start,
  input  logic [DATA_W-1:0]     image_data,
  output logic                  mem_we,
  output logic [DRIVE_W-1:0]    mem_drive,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [5:0]            cur_track,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [NUM_DRIVES-1:0] loaded
`ifdef DISK_IMAGE_LOADER_CKSUM_EN
  , output logic [15:0]         cksum
`endif
);

  localparam int OFF_W = addr_width(TRACK_BYTES);
  localparam logic [OFF_W-1:0]  OFF_LAST  = OFF_W'(TRACK_BYTES - 1);
  localparam logic [5:0]        TRK_LAST  = 6'(TRACKS - 1);
  localparam logic [DATA_W-1:0] DRV_LIMIT = DATA_W'(NUM_DRIVES);

  logic              strobe;
  logic              strb_q;
  logic              start_q;
  logic [DATA_W-1:0] data_q;

  state_t             state_q, state_d;
  logic [DRIVE_W-1:0] drive_q;
  logic [OFF_W-1:0]   offset_q;
  logic [5:0]         track_q;
  logic [ADDR_W-1:0]  addr_q;

  logic do_start, do_write, do_stop, set_err, stop_ok, drive_ok;
  logic last_byte, last_track;

  strobe_sync u_sync (
    .clk      (CLK_14M),
    .rst      (RESET),
    .async_in (image_clk),
    .strobe   (strobe)
  );

  // The PS holds start/data stable well around the strobe, so a plain capture suffices.
  always_ff @(posedge CLK_14M or posedge RESET) begin
    if (RESET) begin
      strb_q  <= 1'b0;
      start_q <= 1'b0;
      data_q  <= '0;
    end else begin
      strb_q <= strobe;
      if (strobe) begin
        start_q <= image_start;
        data_q  <= image_data;
      end
    end
  end

  assign drive_ok   = data_q < DRV_LIMIT;
  assign last_byte  = offset_q == OFF_LAST;
  assign last_track = track_q == TRK_LAST;

`ifdef DISK_IMAGE_LOADER_CKSUM_EN
  logic [15:0] cksum_q;
  assign stop_ok = data_q == cksum_q[DATA_W-1:0];
  assign cksum   = cksum_q;
`else
  assign stop_ok = 1'b1;
`endif

  always_ff @(posedge CLK_14M or posedge RESET) begin
    if (RESET) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    do_start = 1'b0;
    do_write = 1'b0;
    do_stop  = 1'b0;
    set_err  = 1'b0;
    if (strb_q) begin
      if (start_q) begin
        // A start outside IDLE aborts the current load before restarting.
        if (state_q != IDLE) set_err = 1'b1;
        if (drive_ok) begin
          do_start = 1'b1;
          state_d  = RECEIVE;
        end else begin
          set_err = 1'b1;
          state_d = IDLE;
        end
      end else begin
        case (state_q)
          RECEIVE: begin
            do_write = 1'b1;
            if (last_byte && last_track) state_d = WAIT_STOP;
          end
          WAIT_STOP: begin
            do_stop = 1'b1;
            if (!stop_ok) set_err = 1'b1;
            state_d = IDLE;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge CLK_14M or posedge RESET) begin
    if (RESET) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      done      <= 1'b0;
      error     <= 1'b0;
      loaded    <= '0;
      drive_q   <= '0;
      offset_q  <= '0;
      track_q   <= '0;
      addr_q    <= '0;
`ifdef DISK_IMAGE_LOADER_CKSUM_EN
      cksum_q   <= '0;
`endif
    end else begin
      mem_we <= do_write;
      done   <= do_stop && stop_ok;
      if (do_start) begin
        drive_q  <= data_q[DRIVE_W-1:0];
        offset_q <= '0;
        track_q  <= '0;
        addr_q   <= '0;
        error    <= 1'b0;
        loaded[data_q[DRIVE_W-1:0]] <= 1'b0;
`ifdef DISK_IMAGE_LOADER_CKSUM_EN
        cksum_q  <= '0;
`endif
      end else if (do_write) begin
        mem_addr  <= addr_q;
        mem_wdata <= data_q;
        addr_q    <= addr_q + ADDR_W'(1);
`ifdef DISK_IMAGE_LOADER_CKSUM_EN
        cksum_q   <= cksum_q + 16'(data_q);
`endif
        if (last_byte) begin
          offset_q <= '0;
          if (!last_track) track_q <= track_q + 6'd1;
        end else begin
          offset_q <= offset_q + OFF_W'(1);
        end
      end
      if (do_stop && stop_ok) loaded[drive_q] <= 1'b1;
      if (set_err) error <= 1'b1;
    end
  end

  assign mem_drive = drive_q;
  assign cur_track = track_q;
  assign busy      = state_q != IDLE;

endmodule
